// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle MIPS control unit
// Holds FSM state codes, ALU/NPC/GPR/WD select encodings, instruction classes
// and the opcode/funct constants used by the decoder.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_ILL, CL_RALU, CL_IALU, CL_LW, CL_SW,
    CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_JALR
  } cls_t;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_REG    = 2'd3;

  localparam logic [1:0] GPR_RD  = 2'd0;
  localparam logic [1:0] GPR_RT  = 2'd1;
  localparam logic [1:0] GPR_R31 = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

endpackage

// File: rtl/mc_ctrl_dec.sv
// rtl/mc_ctrl_dec.sv - combinational Op/Funct decode to class and ALU code
// Ports: op, funct in; cls (instruction class), alu_code (4-bit ALU op),
// ext_op (sign-extend), src_a (shamt to A), src_b (immediate to B) out.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [3:0] alu_code,
  output logic       ext_op,
  output logic       src_a,
  output logic       src_b
);

  always_comb begin
    cls      = CL_ILL;
    alu_code = ALU_NOP;
    ext_op   = 1'b0;
    src_a    = 1'b0;
    src_b    = 1'b0;
    case (op)
      OP_RTYPE: begin
        cls = CL_RALU;
        case (funct)
          FN_ADD, FN_ADDU: alu_code = ALU_ADD;
          FN_SUB, FN_SUBU: alu_code = ALU_SUB;
          FN_AND:          alu_code = ALU_AND;
          FN_OR:           alu_code = ALU_OR;
          FN_NOR:          alu_code = ALU_NOR;
          FN_SLT:          alu_code = ALU_SLT;
          FN_SLTU:         alu_code = ALU_SLTU;
          FN_SLL:          begin alu_code = ALU_SLL; src_a = 1'b1; end
          FN_SRL:          begin alu_code = ALU_SRL; src_a = 1'b1; end
          FN_SLLV:         alu_code = ALU_SLL;
          FN_SRLV:         alu_code = ALU_SRL;
          FN_JR:           cls = CL_JR;
          FN_JALR:         cls = CL_JALR;
          default:         cls = CL_ILL;
        endcase
      end
      OP_ADDI: begin cls = CL_IALU; alu_code = ALU_ADD; ext_op = 1'b1; src_b = 1'b1; end
      OP_SLTI: begin cls = CL_IALU; alu_code = ALU_SLT; ext_op = 1'b1; src_b = 1'b1; end
      OP_ANDI: begin cls = CL_IALU; alu_code = ALU_AND; src_b = 1'b1; end
      OP_ORI:  begin cls = CL_IALU; alu_code = ALU_OR;  src_b = 1'b1; end
      OP_LUI:  begin cls = CL_IALU; alu_code = ALU_LUI; src_b = 1'b1; end
      OP_LW:   begin cls = CL_LW;   alu_code = ALU_ADD; ext_op = 1'b1; src_b = 1'b1; end
      OP_SW:   begin cls = CL_SW;   alu_code = ALU_ADD; ext_op = 1'b1; src_b = 1'b1; end
      OP_BEQ:  begin cls = CL_BEQ;  alu_code = ALU_SUB; end
      OP_BNE:  begin cls = CL_BNE;  alu_code = ALU_SUB; end
      OP_J:    cls = CL_J;
      OP_JAL:  cls = CL_JAL;
      default: cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS control FSM with retire counter and bus timeout
// Ports: clk, rst (async, active-high); Op, Funct, Zero, MemReady in;
// PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp, ALUSrcA, ALUSrcB,
// ALUOp, NPCOp, GPRSel, WDSel, IllInstr (combinational controls), BusErr (sticky),
// InstrCnt (retired count), State (current state) out.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int TMO_W   = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               EXTOp,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic               BusErr,
  output logic               IllInstr,
  output logic [CNT_W-1:0]   InstrCnt,
  output logic [2:0]         State
);

  state_t             state_q, next_state;
  logic [TMO_W-1:0]   wait_cnt;
  logic [TMO_W-1:0]   wait_inc;
  logic               tmo;

  cls_t       cls;
  logic [3:0] d_alu;
  logic       d_ext, d_src_a, d_src_b;

  logic pc_write, ir_write, reg_write, mem_read, mem_write, iord;
  logic ext_op, src_a, src_b, ill;
  logic [3:0] alu_op;
  logic [1:0] npc_op, gpr_sel, wd_sel;

  mc_ctrl_dec u_dec (
    .op       (Op),
    .funct    (Funct),
    .cls      (cls),
    .alu_code (d_alu),
    .ext_op   (d_ext),
    .src_a    (d_src_a),
    .src_b    (d_src_b)
  );

  // Timeout fires on the stalled cycle that would bring the counter to all-ones.
  assign wait_inc = wait_cnt + 1'b1;
  assign tmo      = !MemReady && (&wait_inc);

  always_comb begin
    next_state = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ext_op     = 1'b0;
    src_a      = 1'b0;
    src_b      = 1'b0;
    alu_op     = ALU_NOP;
    npc_op     = NPC_PLUS4;
    gpr_sel    = GPR_RD;
    wd_sel     = WD_ALU;
    ill        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (MemReady) begin
          ir_write   = 1'b1;
          next_state = S_DECODE;
        end else if (tmo) begin
          next_state = S_HALT;
        end
      end
      S_DECODE: begin
        if (cls == CL_J) begin
          pc_write   = 1'b1;
          npc_op     = NPC_JUMP;
          next_state = S_FETCH;
        end else if (cls == CL_ILL) begin
          ill        = 1'b1;
          pc_write   = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = d_alu;
        ext_op = d_ext;
        src_a  = d_src_a;
        src_b  = d_src_b;
        case (cls)
          CL_BEQ, CL_BNE: begin
            pc_write   = 1'b1;
            npc_op     = ((cls == CL_BEQ) == Zero) ? NPC_BRANCH : NPC_PLUS4;
            next_state = S_FETCH;
          end
          CL_JR: begin
            pc_write   = 1'b1;
            npc_op     = NPC_REG;
            next_state = S_FETCH;
          end
          CL_LW, CL_SW: next_state = S_MEM;
          default:      next_state = S_WB;
        endcase
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (cls == CL_LW);
        mem_write = (cls != CL_LW);
        if (MemReady) begin
          if (cls == CL_LW) begin
            next_state = S_WB;
          end else begin
            pc_write   = 1'b1;
            next_state = S_FETCH;
          end
        end else if (tmo) begin
          next_state = S_HALT;
        end
      end
      S_WB: begin
        // ALU controls stay up so the combinational result is still valid at writeback.
        alu_op    = d_alu;
        ext_op    = d_ext;
        src_a     = d_src_a;
        src_b     = d_src_b;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (cls)
          CL_JAL:  begin npc_op = NPC_JUMP; gpr_sel = GPR_R31; wd_sel = WD_PC4; end
          CL_JALR: begin npc_op = NPC_REG;  gpr_sel = GPR_RD;  wd_sel = WD_PC4; end
          CL_LW:   begin gpr_sel = GPR_RT;  wd_sel = WD_MEM; end
          CL_IALU: gpr_sel = GPR_RT;
          default: gpr_sel = GPR_RD;
        endcase
        next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      InstrCnt <= '0;
      BusErr   <= 1'b0;
    end else begin
      state_q <= next_state;
      if ((state_q == S_FETCH || state_q == S_MEM) && !MemReady && next_state == state_q)
        wait_cnt <= wait_inc;
      else
        wait_cnt <= '0;
      if (pc_write)
        InstrCnt <= InstrCnt + 1'b1;
      if (next_state == S_HALT)
        BusErr <= 1'b1;
    end
  end

  // Reset masks the combinational controls so FETCH does not request memory while held.
  assign PCWrite  = pc_write  & ~rst;
  assign IRWrite  = ir_write  & ~rst;
  assign RegWrite = reg_write & ~rst;
  assign MemRead  = mem_read  & ~rst;
  assign MemWrite = mem_write & ~rst;
  assign IorD     = iord      & ~rst;
  assign EXTOp    = ext_op    & ~rst;
  assign ALUSrcA  = src_a     & ~rst;
  assign ALUSrcB  = src_b     & ~rst;
  assign IllInstr = ill       & ~rst;
  assign ALUOp    = rst ? '0 : ALUOP_W'(alu_op);
  assign NPCOp    = rst ? 2'd0 : npc_op;
  assign GPRSel   = rst ? 2'd0 : gpr_sel;
  assign WDSel    = rst ? 2'd0 : wd_sel;
  assign State    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl against a trace-level model
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  Op = '0, Funct = '0;
  logic        Zero = 1'b0, MemReady = 1'b0;
  logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD;
  logic        EXTOp, ALUSrcA, ALUSrcB, BusErr, IllInstr;
  logic [3:0]  ALUOp;
  logic [1:0]  NPCOp, GPRSel, WDSel;
  logic [31:0] InstrCnt;
  logic [2:0]  State;

  mc_ctrl #(.ALUOP_W(4), .TMO_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .EXTOp(EXTOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel),
    .BusErr(BusErr), .IllInstr(IllInstr), .InstrCnt(InstrCnt), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic pcw, irw, rgw, mrd, mwr, iord, ext, sa, sb;
    logic [3:0] alu;
    logic [1:0] npc, gsel, wsel;
    logic ill;
  } exp_t;

  typedef struct packed {
    logic mr;
    logic z;
    logic be;
    exp_t e;
  } step_t;

  logic [22:0] act;
  assign act = {State, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp,
                ALUSrcA, ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel, IllInstr};

  localparam int TMO = 15;
  localparam int NI  = 26;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
  localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9;

  // add addu sub subu and or nor slt sltu sll srl sllv srlv jr jalr
  // addi ori andi slti lui lw sw beq bne j jal
  localparam int T_OP [NI] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 8,13,12,10,15, 35,43, 4,5, 2,3};
  localparam int T_FN [NI] = '{32,33,34,35,36,37,39,42,43,0,2,4,6,8,9, 0,0,0,0,0, 0,0, 0,0, 0,0};
  localparam int T_KIND [NI] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,8,9, 1,1,1,1,1, 2,3, 4,5, 6,7};
  localparam int T_ALU [NI] = '{1,1,2,2,3,4,8,5,6,7,9,7,9,0,0, 1,4,3,5,10, 1,1, 2,2, 0,0};
  localparam int T_EXT [NI] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,1,0, 1,1, 0,0, 0,0};
  localparam int T_SA [NI] = '{0,0,0,0,0,0,0,0,0,1,1,0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,0};
  localparam int T_SB [NI] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1, 1,1, 0,0, 0,0};

  step_t       q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] icnt    = '0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    n_tests++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, x, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom & 1);
  endfunction

  function automatic int lookup(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < NI; i++)
      if (int'(op) == T_OP[i] && (op != 6'd0 || int'(fn) == T_FN[i])) return i;
    return -1;
  endfunction

  function automatic logic [14:0] states_of();
    logic [14:0] s = '0;
    for (int i = 0; i < q.size() && i < 5; i++) s = {s[11:0], q[i].e.st};
    return s;
  endfunction

  task automatic halt_tail();
    step_t s;
    for (int i = 0; i < 4; i++) begin
      s = '0; s.e.st = 3'd5; s.be = 1'b1; s.mr = rb(); s.z = rb();
      q.push_back(s);
    end
  endtask

  function automatic void alu_fields(inout step_t s, input int idx);
    s.e.alu = 4'(T_ALU[idx]);
    s.e.ext = (T_EXT[idx] != 0);
    s.e.sa  = (T_SA[idx] != 0);
    s.e.sb  = (T_SB[idx] != 0);
  endfunction

  // Expected per-cycle trace of one instruction: df fetch stalls, dm data stalls.
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input int df, input int dm, input logic z);
    step_t s;
    int idx, kind;
    q.delete();
    idx  = lookup(op, fn);
    kind = (idx < 0) ? -1 : T_KIND[idx];
    for (int i = 0; i < df && i < TMO; i++) begin
      s = '0; s.e.mrd = 1'b1; s.z = rb(); q.push_back(s);
    end
    if (df >= TMO) begin halt_tail(); return; end
    s = '0; s.mr = 1'b1; s.z = rb(); s.e.mrd = 1'b1; s.e.irw = 1'b1; q.push_back(s);
    s = '0; s.mr = rb(); s.z = rb(); s.e.st = 3'd1;
    if (idx < 0) begin
      s.e.ill = 1'b1; s.e.pcw = 1'b1; q.push_back(s); return;
    end
    if (kind == K_J) begin
      s.e.pcw = 1'b1; s.e.npc = 2'd2; q.push_back(s); return;
    end
    q.push_back(s);
    s = '0; s.mr = rb(); s.z = rb(); s.e.st = 3'd2; alu_fields(s, idx);
    if (kind == K_BEQ || kind == K_BNE) begin
      s.z = z; s.e.pcw = 1'b1;
      s.e.npc = (kind == K_BEQ ? z : !z) ? 2'd1 : 2'd0;
      q.push_back(s); return;
    end
    if (kind == K_JR) begin
      s.e.pcw = 1'b1; s.e.npc = 2'd3; q.push_back(s); return;
    end
    q.push_back(s);
    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i < dm && i < TMO; i++) begin
        s = '0; s.e.st = 3'd3; s.e.iord = 1'b1; s.z = rb();
        s.e.mrd = (kind == K_LW); s.e.mwr = (kind == K_SW);
        q.push_back(s);
      end
      if (dm >= TMO) begin halt_tail(); return; end
      s = '0; s.e.st = 3'd3; s.e.iord = 1'b1; s.mr = 1'b1; s.z = rb();
      s.e.mrd = (kind == K_LW); s.e.mwr = (kind == K_SW);
      if (kind == K_SW) begin
        s.e.pcw = 1'b1; q.push_back(s); return;
      end
      q.push_back(s);
    end
    s = '0; s.mr = rb(); s.z = rb(); s.e.st = 3'd4; s.e.rgw = 1'b1; s.e.pcw = 1'b1;
    alu_fields(s, idx);
    if (kind == K_JAL)       begin s.e.npc = 2'd2; s.e.gsel = 2'd2; s.e.wsel = 2'd2; end
    else if (kind == K_JALR) begin s.e.npc = 2'd3; s.e.wsel = 2'd2; end
    else if (kind == K_LW)   begin s.e.gsel = 2'd1; s.e.wsel = 2'd1; end
    else if (kind == K_I)    s.e.gsel = 2'd1;
    q.push_back(s);
  endtask

  // Replays the trace; starts at a rising edge + 1, checks at each falling edge.
  task automatic run_q(input int stop);
    for (int i = 0; i < q.size(); i++) begin
      MemReady = q[i].mr;
      Zero     = q[i].z;
      @(negedge clk);
      chk("outputs", 64'(act), 64'(q[i].e));
      chk("instr_cnt", 64'(InstrCnt), 64'(icnt));
      chk("bus_err", 64'(BusErr), 64'(q[i].be));
      if (i == stop) return;
      if (q[i].e.pcw) icnt = icnt + 1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; MemReady = 1'b1; Op = 6'h2b; Funct = 6'h00;
    #1;
    chk("rst_outputs", 64'(act), 64'd0);
    chk("rst_instr_cnt", 64'(InstrCnt), 64'd0);
    chk("rst_bus_err", 64'(BusErr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_outputs", 64'(act), 64'd0);
    rst  = 1'b0;
    icnt = '0;
  endtask

  initial begin
    int idx;
    logic [5:0] op, fn;
    int df, dm;

    do_reset();

    // add with no stalls
    build(6'h00, 6'h20, 0, 0, 1'b0);
    chk("pin_add_len", 64'(q.size()), 64'd4);
    chk("pin_add_states", 64'(states_of()), 64'({3'd0, 3'd1, 3'd2, 3'd4}));
    chk("pin_add_wb", 64'({q[3].e.rgw, q[3].e.gsel, q[3].e.wsel, q[3].e.alu}),
        64'({1'b1, 2'd0, 2'd0, 4'd1}));
    Op = 6'h00; Funct = 6'h20; run_q(-1);
    chk("add_retired", 64'(InstrCnt), 64'd1);

    build(6'h02, 6'h00, 0, 0, 1'b0);
    chk("pin_j_len", 64'(q.size()), 64'd2);
    Op = 6'h02; Funct = 6'h00; run_q(-1);

    build(6'h04, 6'h00, 0, 0, 1'b1);
    chk("pin_beq_taken", 64'({q.size() == 3, q[2].e.pcw, q[2].e.npc}), 64'({1'b1, 1'b1, 2'd1}));
    Op = 6'h04; run_q(-1);
    build(6'h04, 6'h00, 0, 0, 1'b0);
    chk("pin_beq_not_taken", 64'({q.size() == 3, q[2].e.pcw, q[2].e.npc}), 64'({1'b1, 1'b1, 2'd0}));
    Op = 6'h04; run_q(-1);

    build(6'h23, 6'h00, 0, 0, 1'b0);
    chk("pin_lw_states", 64'(states_of()), 64'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}));
    build(6'h2b, 6'h00, 0, 0, 1'b0);
    chk("pin_sw_len", 64'(q.size()), 64'd4);
    build(6'h23, 6'h00, 0, 3, 1'b0);
    chk("pin_lw_stall_len", 64'(q.size()), 64'd8);
    chk("pin_lw_wb", 64'({q[7].e.wsel, q[7].e.gsel}), 64'({2'd1, 2'd1}));
    Op = 6'h23; run_q(-1);

    build(6'h3f, 6'h00, 0, 0, 1'b0);
    chk("pin_ill", 64'({q.size() == 2, q[1].e.ill, q[1].e.pcw, q[1].e.npc}),
        64'({1'b1, 1'b1, 1'b1, 2'd0}));
    Op = 6'h3f; run_q(-1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom); fn = 6'($urandom);
      end else begin
        idx = int'($urandom_range(0, NI - 1));
        op  = 6'(T_OP[idx]);
        fn  = (T_OP[idx] == 0) ? 6'(T_FN[idx]) : 6'($urandom);
      end
      df = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
      dm = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
      build(op, fn, df, dm, rb());
      Op = op; Funct = fn; run_q(-1);
    end

    // reset during the data phase of a store
    build(6'h2b, 6'h00, 0, 5, 1'b0);
    Op = 6'h2b; Funct = 6'h00; run_q(4);
    #1;
    do_reset();

    // instruction fetch never answered
    build(6'h00, 6'h20, 20, 0, 1'b0);
    chk("pin_tmo_fetch", 64'({q.size() == 19, q[14].e.st, q[15].e.st}), 64'({1'b1, 3'd0, 3'd5}));
    Op = 6'h00; Funct = 6'h20; run_q(-1);
    do_reset();

    // store data phase never answered
    build(6'h2b, 6'h00, 0, 20, 1'b0);
    Op = 6'h2b; Funct = 6'h00; run_q(-1);
    do_reset();

    build(6'h03, 6'h00, 1, 0, 1'b0);
    Op = 6'h03; Funct = 6'h00; run_q(-1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
